// File: rtl/sd_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_framer
// Brief    : Assembles 6-byte SD-style command frames (start byte, 32-bit
//            argument, CRC7 byte) from the SPI receive byte buffer, checks
//            them and offers them to the command decoder via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_framer #(
  parameter int CHECK_CRC = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        CS,
  input  logic        IsInitialized,
  input  logic [7:0]  Buffer,
  input  logic        Changed,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  output logic        crc_ok,
  output logic        frame_error,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARG  = 2'd1,
    S_CRC  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [5:0]  r_index;
  logic [5:0]  w_index_nxt;
  logic [31:0] r_arg;
  logic [31:0] w_arg_nxt;
  logic [6:0]  r_crc;
  logic [6:0]  w_crc_nxt;
  logic [6:0]  r_crc_acc;
  logic [6:0]  w_crc_acc_nxt;
  logic        r_crc_ok;
  logic        w_crc_ok_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_frame_error;
  logic        w_frame_error_nxt;
  logic        r_overrun;
  logic        w_overrun_nxt;
  logic        r_changed_d;
  logic        w_byte_evt;
  logic        w_idle_rules;
  logic        w_crc_match;

  // CRC7, polynomial x^7+x^3+1, one byte folded in MSB first
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in,
                                           input logic [7:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[6] ^ data[i];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  // One event per completed byte: rising edge of the level flag
  assign w_byte_evt = Changed & ~r_changed_d;

  // After five bytes the accumulator holds the expected CRC7
  generate
    if (CHECK_CRC != 0) begin : g_crc_check
      assign w_crc_match = (r_crc_acc == Buffer[7:1]) && Buffer[0];
    end else begin : g_crc_bypass
      assign w_crc_match = 1'b1;
    end
  endgenerate

  // Next-state and next-data decode for the frame sequencer
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_index_nxt       = r_index;
    w_arg_nxt         = r_arg;
    w_crc_nxt         = r_crc;
    w_crc_acc_nxt     = r_crc_acc;
    w_crc_ok_nxt      = r_crc_ok;
    w_valid_nxt       = r_valid;
    w_frame_error_nxt = 1'b0;
    w_overrun_nxt     = 1'b0;
    w_idle_rules      = 1'b0;

    case (r_state)
      S_IDLE: w_idle_rules = 1'b1;
      S_ARG: begin
        if (CS) begin
          w_state_nxt       = S_IDLE;
          w_frame_error_nxt = 1'b1;
        end else if (w_byte_evt) begin
          w_arg_nxt     = {r_arg[23:0], Buffer};
          w_crc_acc_nxt = crc7_byte(r_crc_acc, Buffer);
          w_cnt_nxt     = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_nxt = S_CRC;
        end
      end
      S_CRC: begin
        if (CS) begin
          w_state_nxt       = S_IDLE;
          w_frame_error_nxt = 1'b1;
        end else if (w_byte_evt) begin
          w_crc_nxt    = Buffer[7:1];
          w_crc_ok_nxt = w_crc_match;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        // A byte coinciding with the handshake is treated as if in IDLE
        if (r_valid && cmd_ready) begin
          w_valid_nxt  = 1'b0;
          w_state_nxt  = S_IDLE;
          w_idle_rules = 1'b1;
        end else if (w_byte_evt) begin
          w_overrun_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Start byte (01xxxxxx) opens a frame; fill bytes are ignored
    if (w_idle_rules && w_byte_evt && (Buffer[7:6] == 2'b01)) begin
      w_index_nxt   = Buffer[5:0];
      w_arg_nxt     = 32'd0;
      w_crc_acc_nxt = crc7_byte(7'd0, Buffer);
      w_cnt_nxt     = 2'd0;
      w_state_nxt   = S_ARG;
    end
  end

  // State and frame registers; IsInitialized low acts as a synchronous clear
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 2'd0;
      r_index       <= 6'd0;
      r_arg         <= 32'd0;
      r_crc         <= 7'd0;
      r_crc_acc     <= 7'd0;
      r_crc_ok      <= 1'b0;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
      r_changed_d   <= 1'b0;
    end else if (!IsInitialized) begin
      r_state       <= S_IDLE;
      r_crc_ok      <= 1'b0;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
      r_changed_d   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_index       <= w_index_nxt;
      r_arg         <= w_arg_nxt;
      r_crc         <= w_crc_nxt;
      r_crc_acc     <= w_crc_acc_nxt;
      r_crc_ok      <= w_crc_ok_nxt;
      r_valid       <= w_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_overrun     <= w_overrun_nxt;
      r_changed_d   <= Changed;
    end
  end

  assign cmd_valid   = r_valid;
  assign cmd_index   = r_index;
  assign cmd_arg     = r_arg;
  assign cmd_crc     = r_crc;
  assign crc_ok      = r_crc_ok;
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire
